// File: rtl/bcd_mod_counter.sv
// Multi-digit packed-BCD counter over [MIN_BCD, MAX_BCD] with up/down, checked preload,
// wrap pulse (tc_o) and rejected-preload pulse (load_err_o). Cascade via tc_o -> en_i.
module bcd_mod_counter #(
    parameter int unsigned         DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MAX_BCD = 8'h23,
    parameter logic [4*DIGITS-1:0] MIN_BCD = 8'h00
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  up_dn_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  tc_o,
    output logic                  load_err_o
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic [W-1:0]      inc_val, dec_val;
    logic              tc_q, tc_d;
    logic              load_err_q, load_err_d;
    logic [DIGITS-1:0] is_nine, is_zero;
    logic [DIGITS-1:0] cnt_nib_ok, load_nib_ok;
    logic              count_ok, load_ok;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // Selects the digits below this one; all of them must be 9 (or 0) to ripple in.
        localparam logic [DIGITS-1:0] LowMask = DIGITS'((1 << i) - 1);

        logic [3:0] cur;
        logic [3:0] ld_nib;
        logic       carry_in;
        logic       borrow_in;

        assign cur            = count_q[4*i +: 4];
        assign ld_nib         = load_val_i[4*i +: 4];
        assign is_nine[i]     = (cur == 4'd9);
        assign is_zero[i]     = (cur == 4'd0);
        assign cnt_nib_ok[i]  = (cur <= 4'd9);
        assign load_nib_ok[i] = (ld_nib <= 4'd9);
        assign carry_in       = &(is_nine | ~LowMask);
        assign borrow_in      = &(is_zero | ~LowMask);

        assign inc_val[4*i +: 4] = !carry_in  ? cur : (is_nine[i] ? 4'd0 : cur + 4'd1);
        assign dec_val[4*i +: 4] = !borrow_in ? cur : (is_zero[i] ? 4'd9 : cur - 4'd1);
    end

    assign count_ok = (&cnt_nib_ok) && (count_q >= MIN_BCD) && (count_q <= MAX_BCD);
    assign load_ok  = (&load_nib_ok) && (load_val_i >= MIN_BCD) && (load_val_i <= MAX_BCD);

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                count_d = load_val_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en_i) begin
            if (!count_ok) begin
                // Corrupted state: recover to the bottom of the range without a wrap pulse.
                count_d = MIN_BCD;
            end else if (up_dn_i) begin
                if (count_q == MAX_BCD) begin
                    count_d = MIN_BCD;
                    tc_d    = 1'b1;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (count_q == MIN_BCD) begin
                    count_d = MAX_BCD;
                    tc_d    = 1'b1;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            count_q    <= MIN_BCD;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign count_o    = count_q;
    assign tc_o       = tc_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: seven instances (incl. a seconds->minutes cascade) checked every
// cycle against an integer-arithmetic model, plus directed literal checks.
module tb_bcd_mod_counter;

    localparam int unsigned N = 7;
    // 0: 00-23  1: 01-12  2: 00-59  3: 000-999  4: sec 00-59  5: min 00-59 (en = tc of 4)  6: 07-07
    localparam int unsigned PD   [N] = '{2, 2, 2, 3, 2, 2, 2};
    localparam logic [11:0] PMIN [N] = '{12'h00, 12'h01, 12'h00, 12'h000, 12'h00, 12'h00, 12'h07};
    localparam logic [11:0] PMAX [N] = '{12'h23, 12'h12, 12'h59, 12'h999, 12'h59, 12'h59, 12'h07};

    logic        clkin = 1'b0;
    logic        reset = 1'b0;
    logic [N-1:0] en, up, ld;
    logic [11:0] lv [N];
    logic [N-1:0] en_w, tc_w, err_w;
    logic [11:0] cnt_w [N];

    logic [11:0] m_cnt [N];
    logic        m_tc  [N];
    logic        m_err [N];

    int nchk = 0;
    int nerr = 0;

    always #5 clkin = ~clkin;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int unsigned W = 4 * PD[k];
        logic [W-1:0] c;
        assign en_w[k] = (k == 5) ? tc_w[4] : en[k];
        bcd_mod_counter #(
            .DIGITS (PD[k]),
            .MAX_BCD(PMAX[k][W-1:0]),
            .MIN_BCD(PMIN[k][W-1:0])
        ) u_dut (
            .clkin     (clkin),
            .reset     (reset),
            .en_i      (en_w[k]),
            .up_dn_i   (up[k]),
            .load_i    (ld[k]),
            .load_val_i(lv[k][W-1:0]),
            .count_o   (c),
            .tc_o      (tc_w[k]),
            .load_err_o(err_w[k])
        );
        assign cnt_w[k] = 12'(c);
    end

    function automatic bit is_bcd(input logic [11:0] v, input int d);
        for (int i = 0; i < 3; i++) begin
            if (i < d && v[4*i +: 4] > 4'd9) return 1'b0;
            if (i >= d && v[4*i +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int b2i(input logic [11:0] v);
        return int'(v[3:0]) + 10 * int'(v[7:4]) + 100 * int'(v[11:8]);
    endfunction

    function automatic logic [11:0] i2b(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Reference behaviour on integer values.
    task automatic model_step(input int k, input logic e, input logic u, input logic l,
                              input logic [11:0] lval);
        int v, lo, hi;
        v  = b2i(m_cnt[k]);
        lo = b2i(PMIN[k]);
        hi = b2i(PMAX[k]);
        m_tc[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (l) begin
            if (is_bcd(lval, PD[k]) && b2i(lval) >= lo && b2i(lval) <= hi) m_cnt[k] = lval;
            else m_err[k] = 1'b1;
        end else if (e) begin
            if (!is_bcd(m_cnt[k], PD[k]) || v < lo || v > hi) begin
                m_cnt[k] = PMIN[k];
            end else if (u) begin
                if (v == hi) begin
                    m_cnt[k] = PMIN[k];
                    m_tc[k]  = 1'b1;
                end else m_cnt[k] = i2b(v + 1);
            end else begin
                if (v == lo) begin
                    m_cnt[k] = PMAX[k];
                    m_tc[k]  = 1'b1;
                end else m_cnt[k] = i2b(v - 1);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = PMIN[k];
            m_tc[k]  = 1'b0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d.count", k), cnt_w[k], m_cnt[k]);
            chk($sformatf("u%0d.tc", k), 12'(tc_w[k]), 12'(m_tc[k]));
            chk($sformatf("u%0d.load_err", k), 12'(err_w[k]), 12'(m_err[k]));
        end
    endtask

    task automatic step();
        logic old_tc4;
        @(posedge clkin);
        old_tc4 = m_tc[4];
        for (int k = 0; k < N; k++) begin
            model_step(k, (k == 5) ? old_tc4 : en[k], up[k], ld[k], lv[k]);
        end
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        en = '0;
        up = '0;
        ld = '0;
        for (int k = 0; k < N; k++) lv[k] = 12'h000;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    function automatic logic [11:0] rand_val(input int d);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
        end
        return r;
    endfunction

    initial begin
        idle_all();
        #1 reset = 1'b1;
        #2;
        model_reset();
        compare_all();
        chk("reset u0 lit", cnt_w[0], 12'h00);
        chk("reset u1 lit", cnt_w[1], 12'h01);
        #4 reset = 1'b0;

        // Default range up-count, plus the single-value range wrapping every cycle.
        en[0] = 1'b1; up[0] = 1'b1;
        en[6] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            up[6] = i[0];
            step();
            if (i == 9)  chk("u0 09->10 carry", cnt_w[0], 12'h10);
            if (i == 23) chk("u0 23->00", cnt_w[0], 12'h00);
            if (i == 23) chk("u0 tc at wrap", 12'(tc_w[0]), 12'h1);
            if (i == 24) chk("u0 tc one cycle", 12'(tc_w[0]), 12'h0);
            if (i == 29) chk("u0 ends 06", cnt_w[0], 12'h06);
            if (i >= 1 && i <= 3) chk("u6 tc every cycle", 12'(tc_w[6]), 12'h1);
        end
        idle_all();

        // 01-12 range: up wrap then down wrap with borrows.
        en[1] = 1'b1; up[1] = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("u1 12->01", cnt_w[1], 12'h01);
        chk("u1 up tc", 12'(tc_w[1]), 12'h1);
        up[1] = 1'b0;
        step();
        chk("u1 01->12", cnt_w[1], 12'h12);
        chk("u1 down tc", 12'(tc_w[1]), 12'h1);
        for (int i = 0; i < 3; i++) step();
        chk("u1 borrow 10->09", cnt_w[1], 12'h09);
        idle_all();

        // Preload acceptance and rejection, en ignored while loading.
        en[2] = 1'b1; up[2] = 1'b1; ld[2] = 1'b1; lv[2] = 12'h45;
        step();
        chk("u2 load 45", cnt_w[2], 12'h45);
        lv[2] = 12'h4A;
        step();
        chk("u2 4A holds", cnt_w[2], 12'h45);
        chk("u2 4A err", 12'(err_w[2]), 12'h1);
        lv[2] = 12'h60;
        step();
        chk("u2 60 err", 12'(err_w[2]), 12'h1);
        idle_all();
        step();
        chk("u2 err clears", 12'(err_w[2]), 12'h0);

        // Three digits: full ripple carry and wrap.
        ld[3] = 1'b1; lv[3] = 12'h099;
        step();
        ld[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b1;
        step();
        chk("u3 099->100", cnt_w[3], 12'h100);
        ld[3] = 1'b1; lv[3] = 12'h999;
        step();
        ld[3] = 1'b0;
        step();
        chk("u3 999->000", cnt_w[3], 12'h000);
        chk("u3 tc", 12'(tc_w[3]), 12'h1);
        idle_all();

        // Cascade: seconds 58, minutes 59.
        ld[4] = 1'b1; lv[4] = 12'h58; ld[5] = 1'b1; lv[5] = 12'h59; up[5] = 1'b1;
        step();
        ld[4] = 1'b0; ld[5] = 1'b0; en[4] = 1'b1; up[4] = 1'b1;
        step();
        step();
        chk("sec wrap 00", cnt_w[4], 12'h00);
        chk("sec tc", 12'(tc_w[4]), 12'h1);
        chk("min still 59", cnt_w[5], 12'h59);
        step();
        chk("min wrap 00", cnt_w[5], 12'h00);
        chk("min tc", 12'(tc_w[5]), 12'h1);
        en[4] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("sec hold", cnt_w[4], 12'h01);
        chk("min hold", cnt_w[5], 12'h00);
        idle_all();

        // Async reset mid-cycle while a load is pending.
        ld[0] = 1'b1; lv[0] = 12'h17;
        step();
        chk("u0 load 17", cnt_w[0], 12'h17);
        reset_pulse();
        chk("u0 async reset", cnt_w[0], 12'h00);
        idle_all();
        step();

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                en[k] = ($urandom_range(3) != 0);
                up[k] = 1'($urandom_range(1));
                ld[k] = ($urandom_range(7) == 0);
                lv[k] = rand_val(PD[k]);
            end
            step();
            if ($urandom_range(199) == 0) reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
